mem_ctrl_stage: RTL
===================

MEM_CTRL_STAGE -- requirements
Module: mem_ctrl_stage

Interface
REQ-001 Parameters SHALL be as follows.
  XLEN, 32, datapath width (32 or 64).
  TO_CYC, 15, max WAIT cycles before bus timeout (1..255).
REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
  clk  in  1  clock; all state on rising edge.
  rst  in  1  reset, asynchronous, active-low.
  keep  in  1  hold all output registers.
  nop  in  1  squash current stage contents.
  in_valid  in  1  stage holds a live instruction.
  RegWrite_in  in  1  writeback enable.
  MemtoReg_in  in  2  writeback source select, passed through.
  MemRW_in  in  2  bit1 load, bit0 store; 00 none.
  funct3_in  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  MemBranch_in  in  3  001 BEQ, 010 BNE, 011 BGE, 100 BLT, 101 JAL, 110 JALR.
  PCBranch_in, PCp4_in, alu_in, store_data_in  in  XLEN  target, PC+4, ALU result/address, store data.
  WReg_in  in  5  destination register.
  daddr  out  XLEN  memory address.
  dreq, dwrite  out  1  request, write strobe.
  dsize  out  2  0 byte, 1 half, 2 word.
  wdata  out  XLEN  lane-replicated store data.
  dready_n  in  1  active-low data-valid/ack.
  dbusy  in  1  memory cannot accept a request.
  rdata  in  XLEN  raw read data.
  RegWrite_out, MemtoReg_out, WReg_out, alu_out, PCp4_out, mem_data_out  out  1/2/5/XLEN/XLEN/XLEN  registered WB bundle.
  branch_PC  out  XLEN; branch_taken  out  1  combinational redirect.
  mem_stall  out  1  upstream SHALL hold inputs while high.
  bus_err, misalign  out  1  one-cycle error pulses.

Function
REQ-003 An access is present when in_valid=1, nop=0 and MemRW_in!=00.
REQ-004 FSM states SHALL be IDLE and WAIT; IDLE with access and dbusy=0 -> WAIT; IDLE with dbusy=1 stays IDLE.
REQ-005 dreq SHALL be 1 in IDLE with access and in WAIT; daddr, dwrite, dsize and wdata SHALL be stable throughout.
REQ-006 In WAIT, dready_n=0 -> IDLE and the result is loaded into the WB bundle on the same edge.
REQ-007 A 0..TO_CYC counter SHALL clear on entry to WAIT; on reaching TO_CYC with dready_n=1 -> IDLE, bus_err pulses, RegWrite_out=0.
REQ-008 mem_stall SHALL be (IDLE and access) or (WAIT and dready_n=1).
REQ-009 Loads SHALL select lane by alu_in[1:0]; B/H sign-extend, BU/HU zero-extend to XLEN; W passes through.
REQ-010 Stores: byte replicated 4x, half replicated 2x, word unchanged on wdata.
REQ-011 branch_taken: BEQ/BGE alu_in==0, BNE alu_in!=0, BLT alu_in==1, JAL/JALR always; gated by in_valid and !nop.
REQ-012 branch_PC SHALL be alu_in with bit0 cleared for JALR, else PCBranch_in.
REQ-013 Register priority: keep hold > nop zero > mem_stall bubble (all zero) > normal load.
REQ-014 Non-access instructions SHALL load the WB bundle in one cycle with mem_data_out=0.
REQ-015 keep=1 in WAIT SHALL freeze FSM and counter; the memory handshake is not re-issued.

Reset
REQ-016 rst=0 SHALL force IDLE, counter 0, all registered outputs 0, bus_err=misalign=0, regardless of keep.
REQ-017 Reset during WAIT SHALL abandon the access; dreq SHALL fall asynchronously.

Configuration
REQ-018 With MEM_MISALIGN_TRAP_EN defined, misaligned H (addr[0]=1) or W (addr[1:0]!=0) SHALL not be issued: misalign pulses, bubble loaded, no stall.
REQ-019 Without MEM_MISALIGN_TRAP_EN, misalign SHALL be tied 0 and daddr SHALL be issued aligned down to the access size.

Verification
REQ-020 LB at alu_in=0x103, rdata=0x80FF_1234, dready_n=0 after 1 cycle -> mem_data_out=0xFFFFFF80, mem_stall high 2 cycles.
REQ-021 SH store_data_in=0x0000ABCD, addr 0x202 -> wdata=0xABCDABCD, dsize=1, dwrite=1.
REQ-022 dbusy=1 for 3 cycles then 0 -> dreq high throughout, WAIT entered on 4th edge, stall continuous.
REQ-023 dready_n held 1 -> after TO_CYC=15 WAIT cycles bus_err pulses once, RegWrite_out=0, FSM IDLE.
REQ-024 JALR alu_in=0x1001 -> branch_taken=1, branch_PC=0x1000; with nop=1 -> branch_taken=0.
REQ-025 LW at 0x102: with macro misalign=1 and dreq=0; without macro daddr=0x100.

Source files
------------

// File: rtl/mem_ctrl_stage_if.sv
// Data-memory bus between the MEM pipeline stage (master) and the memory (slave).
// Ports: daddr/dreq/dwrite/dsize/wdata driven by the stage; dready_n/dbusy/rdata
//        returned by the memory (dready_n low = read data valid / write acknowledged).
interface mem_ctrl_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] daddr;
  logic            dreq;
  logic            dwrite;
  logic [1:0]      dsize;
  logic [XLEN-1:0] wdata;
  logic            dready_n;
  logic            dbusy;
  logic [XLEN-1:0] rdata;

  modport master (
    output daddr, dreq, dwrite, dsize, wdata,
    input  dready_n, dbusy, rdata
  );

  modport slave (
    input  daddr, dreq, dwrite, dsize, wdata,
    output dready_n, dbusy, rdata
  );
endinterface

// File: rtl/mem_ctrl_stage.sv
// MEM pipeline stage: issues loads/stores on the data bus, formats load data,
// resolves branches combinationally and registers the writeback bundle.
// Ports: clk/rst (async active-low); pipeline inputs *_in, keep/nop controls;
//        dbus (mem_ctrl_stage_if.master); WB bundle *_out; branch_PC/branch_taken;
//        mem_stall to hold upstream; bus_err/misalign one-cycle pulses.
// Latency: non-access ops 1 cycle; accesses 1 cycle IDLE + >=1 cycle WAIT.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// instead of issuing them aligned down.
module mem_ctrl_stage #(
  parameter int XLEN   = 32,
  parameter int TO_CYC = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            keep,
  input  logic            nop,
  input  logic            in_valid,
  input  logic            RegWrite_in,
  input  logic [1:0]      MemtoReg_in,
  input  logic [1:0]      MemRW_in,
  input  logic [2:0]      funct3_in,
  input  logic [2:0]      MemBranch_in,
  input  logic [XLEN-1:0] PCBranch_in,
  input  logic [XLEN-1:0] PCp4_in,
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] store_data_in,
  input  logic [4:0]      WReg_in,
  mem_ctrl_stage_if.master dbus,
  output logic            RegWrite_out,
  output logic [1:0]      MemtoReg_out,
  output logic [4:0]      WReg_out,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] PCp4_out,
  output logic [XLEN-1:0] mem_data_out,
  output logic [XLEN-1:0] branch_PC,
  output logic            branch_taken,
  output logic            mem_stall,
  output logic            bus_err,
  output logic            misalign
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Timeout fires in the TO_CYC-th WAIT cycle without a response.
  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

  typedef struct packed {
    logic            regwrite;
    logic [1:0]      memtoreg;
    logic [4:0]      wreg;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] pcp4;
    logic [XLEN-1:0] mem_data;
  } wb_t;

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  wb_t        wb_q, wb_d;
  logic       bus_err_q, bus_err_d;
  logic       misalign_q, misalign_d;

  logic            access;
  logic            mis;
  logic            issue;
  logic            resp;
  logic [1:0]      size;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic            br_cond;

  assign access = in_valid & ~nop & (MemRW_in != 2'b00);

  // funct3[1:0]: 00 byte, 01 half, 1x word.
  assign size = (funct3_in[1:0] == 2'b00) ? 2'd0 :
                (funct3_in[1:0] == 2'b01) ? 2'd1 : 2'd2;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = access & (((size == 2'd1) & alu_in[0]) |
                         ((size == 2'd2) & (alu_in[1:0] != 2'b00)));
  assign dbus.daddr = alu_in;
`else
  assign mis = 1'b0;
  always_comb begin
    dbus.daddr = alu_in;
    if (size == 2'd1) dbus.daddr[0] = 1'b0;
    else if (size == 2'd2) dbus.daddr[1:0] = 2'b00;
  end
`endif

  assign issue = access & ~mis;
  assign resp  = (state_q == WAIT) & ~dbus.dready_n;

  // dreq is gated by rst so an in-flight request drops as soon as reset asserts.
  assign dbus.dreq   = rst & (((state_q == IDLE) & issue) | (state_q == WAIT));
  assign dbus.dwrite = MemRW_in[0];
  assign dbus.dsize  = size;

  always_comb begin
    case (size)
      2'd0:    dbus.wdata = {(XLEN/8){store_data_in[7:0]}};
      2'd1:    dbus.wdata = {(XLEN/16){store_data_in[15:0]}};
      default: dbus.wdata = store_data_in;
    endcase
  end

  assign mem_stall = ((state_q == IDLE) & issue) | ((state_q == WAIT) & dbus.dready_n);

  // Load formatting: lane picked by the low address bits.
  assign ld_byte = dbus.rdata[{alu_in[1:0], 3'b000} +: 8];
  assign ld_half = alu_in[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];

  always_comb begin
    case (funct3_in)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dbus.rdata;
    endcase
  end

  // Branch resolution uses the ALU result as the comparison outcome.
  always_comb begin
    case (MemBranch_in)
      3'b001:  br_cond = (alu_in == '0);
      3'b010:  br_cond = (alu_in != '0);
      3'b011:  br_cond = (alu_in == '0);
      3'b100:  br_cond = (alu_in == XLEN'(1));
      3'b101:  br_cond = 1'b1;
      3'b110:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  assign branch_taken = in_valid & ~nop & br_cond;
  assign branch_PC    = (MemBranch_in == 3'b110) ? {alu_in[XLEN-1:1], 1'b0} : PCBranch_in;

  // Bus FSM. keep freezes WAIT so the outstanding access is neither re-issued nor timed out.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue && !dbus.dbusy) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        if (!keep) begin
          if (!dbus.dready_n) begin
            state_d = IDLE;
          end else if (cnt_q == TO_LAST) begin
            state_d   = IDLE;
            bus_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  // WB bundle: keep > nop > stall bubble > normal load (misaligned trap also bubbles).
  always_comb begin
    wb_d       = wb_q;
    misalign_d = mis & ~keep;
    if (keep) begin
      wb_d = wb_q;
    end else if (nop || mem_stall || !in_valid || mis) begin
      wb_d = '0;
    end else begin
      wb_d.regwrite = RegWrite_in;
      wb_d.memtoreg = MemtoReg_in;
      wb_d.wreg     = WReg_in;
      wb_d.alu      = alu_in;
      wb_d.pcp4     = PCp4_in;
      wb_d.mem_data = (resp && MemRW_in[1]) ? ld_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      wb_q       <= '0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_q       <= wb_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  assign RegWrite_out = wb_q.regwrite;
  assign MemtoReg_out = wb_q.memtoreg;
  assign WReg_out     = wb_q.wreg;
  assign alu_out      = wb_q.alu;
  assign PCp4_out     = wb_q.pcp4;
  assign mem_data_out = wb_q.mem_data;
  assign bus_err      = bus_err_q;
  assign misalign     = misalign_q;

endmodule
